pic_host_sequencer: RTL



---
 rtl/pic_host_pkg.sv | 50 +++++
 rtl/pic_strobe_timer.sv | 28 ++
 rtl/pic_host_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pic_host_pkg.sv
// Shared types and constants for the PIC8259A host-side sequencer.
package pic_host_pkg;

  typedef enum logic [3:0] {
    StWaitStart,
    StWSetup,
    StWStrobe,
    StWHold,
    StRun,
    StRSetup,
    StRStrobe,
    StRHold,
    StInta1,
    StIntaGap,
    StInta2,
    StIntaDone
  } state_e;

  typedef enum logic [2:0] {
    StepIcw1,
    StepIcw2,
    StepIcw3,
    StepIcw4,
    StepOcw1
  } step_e;

  localparam logic A0_CMD  = 1'b0;
  localparam logic A0_DATA = 1'b1;

  localparam logic [7:0] ICW1_DEFAULT = 8'h13;
  localparam logic [7:0] ICW2_DEFAULT = 8'h20;
  localparam logic [7:0] ICW3_DEFAULT = 8'h00;
  localparam logic [7:0] ICW4_DEFAULT = 8'h01;
  localparam logic [7:0] OCW1_DEFAULT = 8'h00;

  localparam int unsigned INTA_GAP_CYCLES = 2;

  // ICW3 only exists in cascade mode (SNGL=0); ICW4 only when IC4=1.
  function automatic step_e next_step(step_e s, logic sngl, logic ic4);
    step_e n;
    case (s)
      StepIcw1: n = StepIcw2;
      StepIcw2: n = !sngl ? StepIcw3 : (ic4 ? StepIcw4 : StepOcw1);
      StepIcw3: n = ic4 ? StepIcw4 : StepOcw1;
      default:  n = StepOcw1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pic_strobe_timer.sv
// Loadable down-counter timing strobe lows and the INTA gap; last flags the final clock.
module pic_strobe_timer #(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned W            = $clog2(PULSE_CYCLES + 1)
) (
  input  logic         clk,
  input  logic         reset_bar,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_last
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_last = (r_cnt == '0);

endmodule

// File: rtl/pic_host_sequencer.sv
// Bus master for the PIC8259A: init write sequence, INTA acknowledge and host register access.
module pic_host_sequencer
  import pic_host_pkg::*;
#(
  parameter logic [7:0]  ICW1_VAL     = ICW1_DEFAULT,
  parameter logic [7:0]  ICW2_VAL     = ICW2_DEFAULT,
  parameter logic [7:0]  ICW3_VAL     = ICW3_DEFAULT,
  parameter logic [7:0]  ICW4_VAL     = ICW4_DEFAULT,
  parameter logic [7:0]  OCW1_VAL     = OCW1_DEFAULT,
  parameter int unsigned PULSE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_bar,
  input  logic       start,
  output logic       init_done,
  output logic       busy,
  input  logic       host_rd_req,
  input  logic       host_wr_req,
  input  logic       host_a0,
  input  logic [7:0] host_wdata,
  output logic [7:0] host_rdata,
  output logic       host_ack,
  input  logic       ack_ready,
  output logic       vector_valid,
  output logic [7:0] vector_out,
  output logic       chip_select_bar,
  output logic       read_bar,
  output logic       write_bar,
  output logic       INTA_bar,
  output logic       A0,
  output logic [7:0] data_out,
  input  logic [7:0] data_in,
  input  logic       int_to_cpu
);

  localparam int unsigned TW = $clog2(PULSE_CYCLES + 1);

  state_e       r_state, w_state_d;
  step_e        r_step, w_step_d, w_step_next;
  logic         r_host_op, w_host_op_d;
  logic         r_rearm, w_rearm_d;
  logic         r_int_meta, r_int_s;
  logic         r_a0, w_a0_d;
  logic [7:0]   r_dout, w_dout_d;
  logic [7:0]   r_rdata, w_rdata_d;
  logic [7:0]   r_vector, w_vector_d;
  logic         r_init_done, w_init_done_d;
  logic         r_host_ack, w_host_ack_d;
  logic         r_vector_valid, r_busy;
  logic         r_cs_bar, r_rd_bar, r_wr_bar, r_inta_bar;
  logic         w_init_go;
  logic         w_tmr_load, w_tmr_dec, w_tmr_last;
  logic [TW-1:0] w_tmr_load_val;

  function automatic logic [7:0] step_word(step_e s);
    case (s)
      StepIcw1: return ICW1_VAL;
      StepIcw2: return ICW2_VAL;
      StepIcw3: return ICW3_VAL;
      StepIcw4: return ICW4_VAL;
      default:  return OCW1_VAL;
    endcase
  endfunction

  assign w_step_next = next_step(r_step, ICW1_VAL[1], ICW1_VAL[0]);

  pic_strobe_timer #(
    .PULSE_CYCLES (PULSE_CYCLES),
    .W            (TW)
  ) u_timer (
    .clk        (clk),
    .reset_bar  (reset_bar),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_load_val),
    .i_dec      (w_tmr_dec),
    .o_last     (w_tmr_last)
  );

  always_comb begin
    w_state_d      = r_state;
    w_step_d       = r_step;
    w_host_op_d    = r_host_op;
    w_rearm_d      = r_rearm;
    w_a0_d         = r_a0;
    w_dout_d       = r_dout;
    w_rdata_d      = r_rdata;
    w_vector_d     = r_vector;
    w_init_done_d  = r_init_done;
    w_host_ack_d   = 1'b0;
    w_init_go      = 1'b0;
    w_tmr_load     = 1'b0;
    w_tmr_load_val = TW'(PULSE_CYCLES - 1);
    w_tmr_dec      = 1'b0;

    unique case (r_state)
      StWaitStart: w_init_go = start;
      StWSetup: begin
        w_tmr_load = 1'b1;
        w_state_d  = StWStrobe;
      end
      StWStrobe: begin
        if (w_tmr_last) w_state_d = StWHold;
        else            w_tmr_dec = 1'b1;
      end
      StWHold: begin
        if (r_host_op) begin
          w_state_d    = StRun;
          w_host_ack_d = 1'b1;
        end else if (r_step == StepOcw1) begin
          w_state_d     = StRun;
          w_init_done_d = 1'b1;
        end else begin
          w_step_d  = w_step_next;
          w_a0_d    = A0_DATA;
          w_dout_d  = step_word(w_step_next);
          w_state_d = StWSetup;
        end
      end
      StRun: begin
        if (!r_int_s) w_rearm_d = 1'b1;
        // The ack cycle still shows the old level request; skip it so it is not re-serviced.
        if (start) begin
          w_init_go = 1'b1;
        end else if (r_int_s && r_rearm && ack_ready) begin
          w_state_d  = StInta1;
          w_tmr_load = 1'b1;
        end else if (!r_host_ack && host_wr_req) begin
          w_state_d   = StWSetup;
          w_host_op_d = 1'b1;
          w_a0_d      = host_a0;
          w_dout_d    = host_wdata;
        end else if (!r_host_ack && host_rd_req) begin
          w_state_d   = StRSetup;
          w_host_op_d = 1'b1;
          w_a0_d      = host_a0;
        end
      end
      StRSetup: begin
        w_tmr_load = 1'b1;
        w_state_d  = StRStrobe;
      end
      StRStrobe: begin
        if (w_tmr_last) begin
          w_rdata_d = data_in;
          w_state_d = StRHold;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      StRHold: begin
        w_state_d    = StRun;
        w_host_ack_d = 1'b1;
      end
      StInta1: begin
        if (w_tmr_last) begin
          w_state_d      = StIntaGap;
          w_tmr_load     = 1'b1;
          w_tmr_load_val = TW'(INTA_GAP_CYCLES - 1);
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      StIntaGap: begin
        if (w_tmr_last) begin
          w_state_d  = StInta2;
          w_tmr_load = 1'b1;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      StInta2: begin
        if (w_tmr_last) begin
          w_vector_d = data_in;
          w_state_d  = StIntaDone;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      StIntaDone: begin
        w_rearm_d = 1'b0;
        w_state_d = StRun;
      end
      default: w_state_d = StWaitStart;
    endcase

    if (w_init_go) begin
      w_state_d     = StWSetup;
      w_step_d      = StepIcw1;
      w_host_op_d   = 1'b0;
      w_a0_d        = A0_CMD;
      w_dout_d      = ICW1_VAL;
      w_init_done_d = 1'b0;
    end
  end

  // Strobes are registered decodes of the next state, so they line up with the state they mark.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      r_state        <= StWaitStart;
      r_step         <= StepIcw1;
      r_host_op      <= 1'b0;
      r_rearm        <= 1'b1;
      r_int_meta     <= 1'b0;
      r_int_s        <= 1'b0;
      r_a0           <= 1'b0;
      r_dout         <= 8'h00;
      r_rdata        <= 8'h00;
      r_vector       <= 8'h00;
      r_init_done    <= 1'b0;
      r_host_ack     <= 1'b0;
      r_vector_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_cs_bar       <= 1'b1;
      r_rd_bar       <= 1'b1;
      r_wr_bar       <= 1'b1;
      r_inta_bar     <= 1'b1;
    end else begin
      r_state        <= w_state_d;
      r_step         <= w_step_d;
      r_host_op      <= w_host_op_d;
      r_rearm        <= w_rearm_d;
      r_int_meta     <= int_to_cpu;
      r_int_s        <= r_int_meta;
      r_a0           <= w_a0_d;
      r_dout         <= w_dout_d;
      r_rdata        <= w_rdata_d;
      r_vector       <= w_vector_d;
      r_init_done    <= w_init_done_d;
      r_host_ack     <= w_host_ack_d;
      r_vector_valid <= (w_state_d == StIntaDone);
      r_busy         <= !(w_state_d inside {StWaitStart, StRun});
      r_cs_bar       <= !(w_state_d inside {StWSetup, StWStrobe, StWHold,
                                             StRSetup, StRStrobe, StRHold});
      r_rd_bar       <= (w_state_d != StRStrobe);
      r_wr_bar       <= (w_state_d != StWStrobe);
      r_inta_bar     <= !(w_state_d inside {StInta1, StInta2});
    end
  end

  assign init_done       = r_init_done;
  assign busy            = r_busy;
  assign host_rdata      = r_rdata;
  assign host_ack        = r_host_ack;
  assign vector_valid    = r_vector_valid;
  assign vector_out      = r_vector;
  assign chip_select_bar = r_cs_bar;
  assign read_bar        = r_rd_bar;
  assign write_bar       = r_wr_bar;
  assign INTA_bar        = r_inta_bar;
  assign A0              = r_a0;
  assign data_out        = r_dout;

endmodule
